ltssm_config_lanes: RTL and testbench
=====================================

// Module: ltssm_config_lanes
// PURPOSE
//  Parametrised Configuration-state controller for the PCIe LTSSM, successor to the fixed-width config block.
//  Walks Linkwidth.Start/Accept, Lanenum.Wait/Accept, Config.Complete and Config.Idle with per-state timeouts.
//  Resolves the negotiated link width (largest power of two of contiguous lanes from lane 0).
//  Emits one AXIS descriptor beat per ordered set to the TS/idle generator.
//  Sits between the LTSSM top FSM (en/success/error) and the per-lane TX ordered-set builder.
// PARAMETERS
//  MAX_NUM_LANES  4         lanes supported; power of two, 1..16
//  DATA_WIDTH     32        descriptor tdata width, >=16
//  KEEP_WIDTH     DATA_WIDTH/8  tkeep width
//  USER_WIDTH     5         tuser width; [2:0] = ordered-set type
//  LINK_NUM       0         link number sent in TS1/TS2, 8 bit
//  TO_24MS        24'd6000000  Linkwidth.Start timeout, cycles
//  TO_2MS         24'd500000   timeout for all other states, cycles
//  TS2_TX_MIN     16        TS2 beats sent after first full TS2 receipt
//  IDLE_TX_MIN    16        idle beats sent after first idle receipt
// PORTS
//  clk_i                 in   1    clock
//  rst_i                 in   1    synchronous active-high reset
//  en_i                  in   1    level enable from LTSSM top; low = abort to IDLE
//  lanes_detected_i      in   N    lanes that passed Detect/Polling
//  lanes_ts1_link_i      in   N    per lane: 2 consecutive TS1, non-PAD link number
//  lanes_ts1_lane_i      in   N    per lane: 2 consecutive TS1, non-PAD lane number
//  lanes_ts2_i           in   N    per lane: 8 consecutive TS2 received
//  lanes_idle_i          in   N    per lane: idle data received
//  success_o             out  1    config done, held while en_i high
//  error_o               out  1    timeout, held while en_i high
//  active_lanes_o        out  N    negotiated lane mask, valid from LW_ACCEPT on
//  link_width_o          out  $clog2(N)+1  negotiated lane count
//  state_o               out  4    current state encoding, debug
//  m_axis_tdata_o        out  DATA_WIDTH  [7:0] link num/PAD, [15:8] lane count, rest 0
//  m_axis_tkeep_o        out  KEEP_WIDTH  all ones
//  m_axis_tvalid_o       out  1    descriptor valid
//  m_axis_tlast_o        out  1    always 1 (single-beat descriptors)
//  m_axis_tuser_o        out  USER_WIDTH  [2:0]: 0 TS1_PAD, 1 TS1_LINK, 2 TS1_LANE, 3 TS2, 4 IDLE
//  m_axis_tready_i       in   1    descriptor accept
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except tkeep=all ones, tlast=1; counters and timer 0.
//  States: IDLE, LW_START, LW_ACCEPT, LN_WAIT, LN_ACCEPT, COMPLETE, CFG_IDLE, SUCCESS, ERROR.
//  IDLE->LW_START when en_i=1. en_i=0 in any state -> IDLE next cycle, outputs as reset (abort overrides AXIS hold).
//  LW_START: send TS1_PAD; lane0 in (ts1_link & detected) -> LW_ACCEPT; timer==TO_24MS -> ERROR.
//  LW_ACCEPT (1 cycle): cnt = contiguous ones from lane0 of ts1_link&detected; width = pow2_floor(cnt);
//   latch active_lanes_o=(1<<width)-1, link_width_o=width; -> LN_WAIT.
//  LN_WAIT: send TS1_LANE; all active lanes in ts1_lane -> LN_ACCEPT; timer==TO_2MS -> ERROR.
//  LN_ACCEPT (1 cycle): active still all set -> COMPLETE, else re-resolve width -> LN_WAIT.
//  COMPLETE: send TS2; count accepted TS2 beats once all active lanes ts2; count>=TS2_TX_MIN -> CFG_IDLE.
//  CFG_IDLE: send IDLE; count accepted beats once all active lanes idle; >=IDLE_TX_MIN -> SUCCESS.
//  COMPLETE/CFG_IDLE timeout TO_2MS -> ERROR. Timer clears on every state entry, saturates.
//  SUCCESS/ERROR: flag high, tvalid low after pending beat accepted; exit only via en_i=0.
//  AXIS: one-entry output register; loaded only when empty or (tvalid&&tready); data stable while stalled;
//   beat in flight at state change completes unchanged; next beat reflects new state. Counts use handshakes only.
//  cnt=0 impossible in LW_ACCEPT (lane0 required). Non-contiguous lanes above gap are dropped.
// STRUCTURE
//  Package ltssm_config_pkg: state enum, os_type enum, pow2_floor() and lead_ones() functions.
//  Sub-module ltssm_lane_width_resolver: N-bit mask in -> width, active mask out (combinational).
//  Top holds FSM, timer, TX counters, AXIS output register.
// TESTING
//  T1 N=4, detected=4'hF, all flags asserted in order, tready=1 -> width 4, mask 4'hF, success in < 60 cycles.
//  T2 ts1_link=4'b1011 -> contiguous 2, link_width_o=2, active_lanes_o=4'b0011.
//  T3 ts1_link=4'b0111 -> cnt 3, pow2_floor -> width 2, mask 4'b0011.
//  T4 no lane0 TS1 (TO_24MS=100) -> error_o=1 at cycle 101 after LW_START entry; en_i=0 -> IDLE.
//  T5 tready toggled randomly in COMPLETE -> tdata/tuser stable while stalled; exactly 16 TS2 accepted before CFG_IDLE.
//  T6 en_i dropped mid-LN_WAIT with tvalid=1 -> next cycle state IDLE, tvalid=0, success/error 0.

Source files
------------

// File: rtl/ltssm_config_pkg.sv
// ----------------------------------------------------------------------------
// ltssm_config_pkg
// Shared types and helpers for the PCIe LTSSM Configuration-state controller.
//   state_t     : Configuration sub-state encoding (also exported on state_o)
//   os_type_t   : ordered-set type carried in the descriptor tuser[2:0]
//   lead_ones() : count of contiguous ones starting at bit 0 of a lane mask
//   pow2_floor(): largest power of two not exceeding a lane count
// ----------------------------------------------------------------------------
package ltssm_config_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LW_START  = 4'd1,
        ST_LW_ACCEPT = 4'd2,
        ST_LN_WAIT   = 4'd3,
        ST_LN_ACCEPT = 4'd4,
        ST_COMPLETE  = 4'd5,
        ST_CFG_IDLE  = 4'd6,
        ST_SUCCESS   = 4'd7,
        ST_ERROR     = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        OS_TS1_PAD  = 3'd0,
        OS_TS1_LINK = 3'd1,
        OS_TS1_LANE = 3'd2,
        OS_TS2      = 3'd3,
        OS_IDLE     = 3'd4
    } os_type_t;

    // K23.7 symbol used in place of the link number while the link is unnamed
    localparam logic [7:0] PAD_SYMBOL = 8'hF7;

    // Lane masks are handled as 16 bits here so the helpers work for any
    // supported lane count; narrower masks are zero-extended by the caller.
    function automatic logic [4:0] lead_ones(input logic [15:0] mask);
        logic [4:0] cnt;
        logic       run;
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (run && mask[i]) begin
                cnt = cnt + 5'd1;
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    // Keeps only the highest set bit; 0 maps to 0.
    function automatic logic [4:0] pow2_floor(input logic [4:0] cnt);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            if (cnt[i]) begin
                p = 5'd1 << i;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ltssm_lane_width_resolver.sv
// ----------------------------------------------------------------------------
// ltssm_lane_width_resolver
// Combinational link-width resolution: counts the contiguous run of lanes
// starting at lane 0, rounds it down to a power of two and produces the
// matching low-order active-lane mask. Lanes above a gap are dropped.
//   i_mask       : in  N   candidate lanes
//   o_width      : out WW  negotiated lane count
//   o_activeMask : out N   lanes 0..o_width-1 set
// ----------------------------------------------------------------------------
module ltssm_lane_width_resolver
    import ltssm_config_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = $clog2(N) + 1
) (
    input  logic [N-1:0]  i_mask,
    output logic [WW-1:0] o_width,
    output logic [N-1:0]  o_activeMask
);

    logic [4:0] w_count;
    logic [4:0] w_pow2;

    // Width is rounded down so the link always trains on a legal x1/x2/x4...
    always_comb begin
        w_count = lead_ones(16'(i_mask));
        w_pow2  = pow2_floor(w_count);
        o_width = WW'(w_pow2);
        o_activeMask = '0;
        for (int i = 0; i < N; i++) begin
            o_activeMask[i] = (i < int'(w_pow2));
        end
    end

endmodule

// File: rtl/ltssm_config_lanes.sv
// ----------------------------------------------------------------------------
// ltssm_config_lanes
// Configuration-state controller for the PCIe LTSSM. Walks Linkwidth.Start/
// Accept, Lanenum.Wait/Accept, Config.Complete and Config.Idle, resolves the
// link width and issues one AXIS descriptor beat per ordered set.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   en_i                  : level enable, low aborts to IDLE
//   lanes_*_i             : per-lane receive status from the lane receivers
//   success_o / error_o   : completion / timeout flags, held while en_i high
//   active_lanes_o        : negotiated lane mask
//   link_width_o          : negotiated lane count
//   state_o               : current state (debug)
//   m_axis_*              : descriptor stream to the TS/idle generator
// ----------------------------------------------------------------------------
module ltssm_config_lanes
    import ltssm_config_pkg::*;
#(
    parameter int          MAX_NUM_LANES = 4,
    parameter int          DATA_WIDTH    = 32,
    parameter int          KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int          USER_WIDTH    = 5,
    parameter logic [7:0]  LINK_NUM      = 8'd0,
    parameter logic [23:0] TO_24MS       = 24'd6000000,
    parameter logic [23:0] TO_2MS        = 24'd500000,
    parameter int          TS2_TX_MIN    = 16,
    parameter int          IDLE_TX_MIN   = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic [MAX_NUM_LANES-1:0]         lanes_detected_i,
    input  logic [MAX_NUM_LANES-1:0]         lanes_ts1_link_i,
    input  logic [MAX_NUM_LANES-1:0]         lanes_ts1_lane_i,
    input  logic [MAX_NUM_LANES-1:0]         lanes_ts2_i,
    input  logic [MAX_NUM_LANES-1:0]         lanes_idle_i,
    output logic                             success_o,
    output logic                             error_o,
    output logic [MAX_NUM_LANES-1:0]         active_lanes_o,
    output logic [$clog2(MAX_NUM_LANES):0]   link_width_o,
    output logic [3:0]                       state_o,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep_o,
    output logic                             m_axis_tvalid_o,
    output logic                             m_axis_tlast_o,
    output logic [USER_WIDTH-1:0]            m_axis_tuser_o,
    input  logic                             m_axis_tready_i
);

    localparam int          N  = MAX_NUM_LANES;
    localparam int          LW = $clog2(MAX_NUM_LANES) + 1;
    localparam logic [15:0] TS2_MIN16  = 16'(TS2_TX_MIN);
    localparam logic [15:0] IDLE_MIN16 = 16'(IDLE_TX_MIN);

    state_t                r_state;
    state_t                w_nextState;
    logic [23:0]           r_timer;
    logic [15:0]           r_txCount;
    logic                  r_rxSeen;
    logic [N-1:0]          r_activeLanes;
    logic [LW-1:0]         r_linkWidth;
    logic                  r_success;
    logic                  r_error;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [USER_WIDTH-1:0] r_tuser;

    logic                  w_handshake;
    logic                  w_loadEnable;
    logic [N-1:0]          w_resolverIn;
    logic [LW-1:0]         w_resolvedWidth;
    logic [N-1:0]          w_resolvedMask;
    logic                  w_allLane;
    logic                  w_allTs2;
    logic                  w_allIdle;
    logic                  w_rxAll;
    logic                  w_countedBeat;
    logic [15:0]           w_countNext;
    logic                  w_timeout2;
    logic                  w_sendValid;
    os_type_t              w_beatType;
    logic [DATA_WIDTH-1:0] w_beatData;

    // Linkwidth.Accept resolves from link-numbered TS1s; a Lanenum.Accept
    // retry resolves from the lanes that still report a lane number.
    assign w_resolverIn = (r_state == ST_LW_ACCEPT) ? (lanes_ts1_link_i & lanes_detected_i)
                                                    : (lanes_ts1_lane_i & lanes_detected_i);

    ltssm_lane_width_resolver #(
        .N  (N),
        .WW (LW)
    ) u_resolver (
        .i_mask       (w_resolverIn),
        .o_width      (w_resolvedWidth),
        .o_activeMask (w_resolvedMask)
    );

    assign w_handshake  = r_tvalid & m_axis_tready_i;
    assign w_loadEnable = ~r_tvalid | m_axis_tready_i;
    assign w_allLane    = ((lanes_ts1_lane_i & r_activeLanes) == r_activeLanes);
    assign w_allTs2     = ((lanes_ts2_i & r_activeLanes) == r_activeLanes);
    assign w_allIdle    = ((lanes_idle_i & r_activeLanes) == r_activeLanes);
    assign w_rxAll      = (r_state == ST_COMPLETE) ? w_allTs2 : w_allIdle;
    assign w_timeout2   = (r_timer >= TO_2MS);

    // Only handshakes of this state's own ordered-set type count, so a beat
    // still in flight from the previous state is never credited here.
    assign w_countedBeat = ((r_state == ST_COMPLETE) || (r_state == ST_CFG_IDLE)) &&
                           w_handshake && (r_tuser[2:0] == w_beatType) &&
                           (r_rxSeen || w_rxAll);
    assign w_countNext   = r_txCount + (w_countedBeat ? 16'd1 : 16'd0);

    // Next-state selection; progress is checked before the timeout.
    always_comb begin
        w_nextState = r_state;
        if (!en_i) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_nextState = ST_LW_START;
                ST_LW_START: begin
                    if (lanes_ts1_link_i[0] && lanes_detected_i[0]) w_nextState = ST_LW_ACCEPT;
                    else if (r_timer >= TO_24MS)                    w_nextState = ST_ERROR;
                end
                ST_LW_ACCEPT: w_nextState = ST_LN_WAIT;
                ST_LN_WAIT: begin
                    if (w_allLane)       w_nextState = ST_LN_ACCEPT;
                    else if (w_timeout2) w_nextState = ST_ERROR;
                end
                ST_LN_ACCEPT: w_nextState = w_allLane ? ST_COMPLETE : ST_LN_WAIT;
                ST_COMPLETE: begin
                    if (w_countNext >= TS2_MIN16) w_nextState = ST_CFG_IDLE;
                    else if (w_timeout2)          w_nextState = ST_ERROR;
                end
                ST_CFG_IDLE: begin
                    if (w_countNext >= IDLE_MIN16) w_nextState = ST_SUCCESS;
                    else if (w_timeout2)           w_nextState = ST_ERROR;
                end
                ST_SUCCESS:   w_nextState = ST_SUCCESS;
                ST_ERROR:     w_nextState = ST_ERROR;
                default:      w_nextState = ST_IDLE;
            endcase
        end
    end

    // Ordered set generated for the current state.
    always_comb begin
        w_sendValid = 1'b0;
        w_beatType  = OS_TS1_PAD;
        case (r_state)
            ST_LW_START: begin w_sendValid = 1'b1; w_beatType = OS_TS1_PAD;  end
            ST_LN_WAIT:  begin w_sendValid = 1'b1; w_beatType = OS_TS1_LANE; end
            ST_COMPLETE: begin w_sendValid = 1'b1; w_beatType = OS_TS2;      end
            ST_CFG_IDLE: begin w_sendValid = 1'b1; w_beatType = OS_IDLE;     end
            default:     begin w_sendValid = 1'b0; w_beatType = OS_TS1_PAD;  end
        endcase
        w_beatData        = '0;
        w_beatData[7:0]   = (w_beatType == OS_TS1_PAD) ? PAD_SYMBOL : LINK_NUM;
        w_beatData[15:8]  = 8'(r_linkWidth);
    end

    // State register with per-state timer and TX counter, both cleared on
    // every state change; flags are registered against the next state so
    // they line up with state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_txCount     <= '0;
            r_rxSeen      <= 1'b0;
            r_activeLanes <= '0;
            r_linkWidth   <= '0;
            r_success     <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_success <= (w_nextState == ST_SUCCESS);
            r_error   <= (w_nextState == ST_ERROR);
            if (w_nextState != r_state) begin
                r_timer   <= '0;
                r_txCount <= '0;
                r_rxSeen  <= 1'b0;
            end else begin
                if (r_timer != '1) r_timer <= r_timer + 24'd1;
                r_txCount <= w_countNext;
                if (((r_state == ST_COMPLETE) || (r_state == ST_CFG_IDLE)) && w_rxAll) begin
                    r_rxSeen <= 1'b1;
                end
            end
            if (!en_i) begin
                r_activeLanes <= '0;
                r_linkWidth   <= '0;
            end else if ((r_state == ST_LW_ACCEPT) || ((r_state == ST_LN_ACCEPT) && !w_allLane)) begin
                r_activeLanes <= w_resolvedMask;
                r_linkWidth   <= w_resolvedWidth;
            end
        end
    end

    // One-entry descriptor register: reloads only when empty or draining,
    // so a stalled beat stays put across state changes; abort empties it.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= '0;
        end else if (w_loadEnable) begin
            r_tvalid <= w_sendValid;
            r_tdata  <= w_sendValid ? w_beatData : '0;
            r_tuser  <= '0;
            if (w_sendValid) r_tuser[2:0] <= w_beatType;
        end
    end

    assign success_o       = r_success;
    assign error_o         = r_error;
    assign active_lanes_o  = r_activeLanes;
    assign link_width_o    = r_linkWidth;
    assign state_o         = r_state;
    assign m_axis_tdata_o  = r_tdata;
    assign m_axis_tkeep_o  = '1;
    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tlast_o  = 1'b1;
    assign m_axis_tuser_o  = r_tuser;

endmodule

// File: tb/tb_ltssm_config_lanes.sv
// ----------------------------------------------------------------------------
// tb_ltssm_config_lanes
// Self-checking bench for ltssm_config_lanes (4 lanes, short timeouts).
// ----------------------------------------------------------------------------
module tb_ltssm_config_lanes;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LW_START = 4'd1;
    localparam logic [3:0] S_LN_WAIT  = 4'd3;
    localparam logic [3:0] S_COMPLETE = 4'd5;
    localparam logic [3:0] S_CFG_IDLE = 4'd6;
    localparam logic [3:0] S_SUCCESS  = 4'd7;
    localparam logic [3:0] S_ERROR    = 4'd8;
    localparam logic [7:0] LINK       = 8'h05;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  detected, ts1Link, ts1Lane, ts2, idle;
    logic        success, error;
    logic [3:0]  activeLanes;
    logic [2:0]  linkWidth;
    logic [3:0]  state;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast, tready;
    logic [4:0]  tuser;

    int passCount  = 0;
    int totalCount = 0;
    int cycleCount = 0;

    typedef struct {
        logic [3:0] det;
        logic [3:0] link;
        logic [2:0] width;
        logic [3:0] mask;
    } vec_t;

    vec_t vecs[7];

    ltssm_config_lanes #(
        .MAX_NUM_LANES (4),
        .DATA_WIDTH    (32),
        .KEEP_WIDTH    (4),
        .USER_WIDTH    (5),
        .LINK_NUM      (LINK),
        .TO_24MS       (24'd100),
        .TO_2MS        (24'd200),
        .TS2_TX_MIN    (16),
        .IDLE_TX_MIN   (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_i             (en),
        .lanes_detected_i (detected),
        .lanes_ts1_link_i (ts1Link),
        .lanes_ts1_lane_i (ts1Lane),
        .lanes_ts2_i      (ts2),
        .lanes_idle_i     (idle),
        .success_o        (success),
        .error_o          (error),
        .active_lanes_o   (activeLanes),
        .link_width_o     (linkWidth),
        .state_o          (state),
        .m_axis_tdata_o   (tdata),
        .m_axis_tkeep_o   (tkeep),
        .m_axis_tvalid_o  (tvalid),
        .m_axis_tlast_o   (tlast),
        .m_axis_tuser_o   (tuser),
        .m_axis_tready_i  (tready)
    );

    // Free-running clock and cycle counter for latency measurement
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point: every check is counted here
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drop en_i for two cycles, then drive the lane status and re-enable
    task automatic applyStimulus(input logic [3:0] d, input logic [3:0] lk, input logic [3:0] ln,
                                 input logic [3:0] t2, input logic [3:0] il);
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        detected = d;
        ts1Link  = lk;
        ts1Lane  = ln;
        ts2      = t2;
        idle     = il;
        en       = 1'b1;
    endtask

    // Bounded wait for a state; an expired bound is a failed check
    task automatic waitState(input logic [3:0] s, input int maxCycles, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < maxCycles && !found; i++) begin
            @(posedge clk);
            #1;
            if (state == s) found = 1'b1;
        end
        checkOutput(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        int startCycle;
        int ts2Count;
        logic prevStall;
        logic [31:0] savedData;
        logic [4:0]  savedUser;
        logic reached;

        vecs[0] = '{det: 4'hF,    link: 4'hF,    width: 3'd4, mask: 4'hF};
        vecs[1] = '{det: 4'hF,    link: 4'b1011, width: 3'd2, mask: 4'b0011};
        vecs[2] = '{det: 4'hF,    link: 4'b0111, width: 3'd2, mask: 4'b0011};
        vecs[3] = '{det: 4'hF,    link: 4'b0001, width: 3'd1, mask: 4'b0001};
        vecs[4] = '{det: 4'hF,    link: 4'b1101, width: 3'd1, mask: 4'b0001};
        vecs[5] = '{det: 4'b0111, link: 4'hF,    width: 3'd2, mask: 4'b0011};
        vecs[6] = '{det: 4'b0011, link: 4'hF,    width: 3'd2, mask: 4'b0011};

        rst = 1'b1; en = 1'b0; tready = 1'b1;
        detected = '0; ts1Link = '0; ts1Lane = '0; ts2 = '0; idle = '0;
        stepCycles(3);
        @(negedge clk);
        rst = 1'b0;
        stepCycles(1);

        // Reset state
        checkOutput("rst_state",   {28'd0, state}, {28'd0, S_IDLE});
        checkOutput("rst_tvalid",  {31'd0, tvalid}, 32'd0);
        checkOutput("rst_tkeep",   {28'd0, tkeep}, 32'hF);
        checkOutput("rst_tlast",   {31'd0, tlast}, 32'd1);
        checkOutput("rst_flags",   {30'd0, success, error}, 32'd0);
        checkOutput("rst_lanes",   {25'd0, linkWidth, activeLanes}, 32'd0);

        // Width resolution table: lanes stay silent on lane numbers, so the
        // FSM parks in LN_WAIT sending TS1_LANE with the resolved width
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].det, vecs[v].link, 4'h0, 4'h0, 4'h0);
            waitState(S_LN_WAIT, 10, $sformatf("vec%0d_reach_ln_wait", v));
            checkOutput($sformatf("vec%0d_width", v), {29'd0, linkWidth}, {29'd0, vecs[v].width});
            checkOutput($sformatf("vec%0d_mask", v), {28'd0, activeLanes}, {28'd0, vecs[v].mask});
            stepCycles(1);
            checkOutput($sformatf("vec%0d_tuser", v), {27'd0, tuser}, 32'd2);
            checkOutput($sformatf("vec%0d_tdata", v), tdata, {16'd0, 5'd0, vecs[v].width, LINK});
        end

        // Full x4 training with every lane ready
        applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        startCycle = cycleCount;
        waitState(S_COMPLETE, 20, "t1_reach_complete");
        stepCycles(1);
        checkOutput("t1_ts2_valid", {31'd0, tvalid}, 32'd1);
        checkOutput("t1_ts2_tuser", {27'd0, tuser}, 32'd3);
        checkOutput("t1_ts2_tdata", tdata, 32'h0000_0405);
        waitState(S_SUCCESS, 80, "t1_reach_success");
        checkOutput("t1_latency_lt60", {31'd0, (cycleCount - startCycle) < 60}, 32'd1);
        checkOutput("t1_success", {30'd0, success, error}, 32'd2);
        checkOutput("t1_width", {29'd0, linkWidth}, 32'd4);
        checkOutput("t1_mask", {28'd0, activeLanes}, 32'hF);
        stepCycles(2);
        checkOutput("t1_tvalid_drained", {31'd0, tvalid}, 32'd0);
        checkOutput("t1_success_held", {31'd0, success}, 32'd1);

        // Linkwidth.Start timeout with lane 0 never reporting
        applyStimulus(4'hF, 4'b1110, 4'h0, 4'h0, 4'h0);
        waitState(S_LW_START, 5, "t4_reach_lw_start");
        stepCycles(1);
        checkOutput("t4_pad_tuser", {27'd0, tuser}, 32'd0);
        checkOutput("t4_pad_tdata", tdata, 32'h0000_00F7);
        stepCycles(99);
        checkOutput("t4_state_at_100", {28'd0, state}, {28'd0, S_LW_START});
        checkOutput("t4_error_at_100", {31'd0, error}, 32'd0);
        stepCycles(1);
        checkOutput("t4_state_at_101", {28'd0, state}, {28'd0, S_ERROR});
        checkOutput("t4_error_at_101", {31'd0, error}, 32'd1);
        stepCycles(3);
        checkOutput("t4_error_held", {31'd0, error}, 32'd1);
        @(negedge clk);
        en = 1'b0;
        stepCycles(1);
        checkOutput("t4_abort_state", {28'd0, state}, {28'd0, S_IDLE});
        checkOutput("t4_abort_error", {31'd0, error}, 32'd0);

        // Random back-pressure in COMPLETE
        applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        waitState(S_COMPLETE, 20, "t5_reach_complete");
        ts2Count  = 0;
        prevStall = 1'b0;
        savedData = '0;
        savedUser = '0;
        reached   = 1'b0;
        for (int c = 0; c < 500 && !reached; c++) begin
            @(negedge clk);
            if (prevStall) begin
                checkOutput("t5_stall_valid", {31'd0, tvalid}, 32'd1);
                checkOutput("t5_stall_tdata", tdata, savedData);
                checkOutput("t5_stall_tuser", {27'd0, tuser}, {27'd0, savedUser});
            end
            if (state != S_COMPLETE) begin
                reached = 1'b1;
            end else begin
                tready = 1'($urandom_range(0, 1));
                if (tvalid && tready && tuser == 5'd3) ts2Count++;
                prevStall = tvalid && !tready;
                savedData = tdata;
                savedUser = tuser;
            end
        end
        checkOutput("t5_left_complete", {31'd0, reached}, 32'd1);
        checkOutput("t5_next_state", {28'd0, state}, {28'd0, S_CFG_IDLE});
        checkOutput("t5_ts2_count", ts2Count, 32'd16);
        tready = 1'b1;

        // Abort from LN_WAIT while a stalled beat is held
        @(negedge clk);
        tready = 1'b0;
        applyStimulus(4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        waitState(S_LN_WAIT, 10, "t6_reach_ln_wait");
        stepCycles(2);
        checkOutput("t6_held_valid", {31'd0, tvalid}, 32'd1);
        checkOutput("t6_held_tuser", {27'd0, tuser}, 32'd0);
        @(negedge clk);
        en = 1'b0;
        stepCycles(1);
        checkOutput("t6_abort_state", {28'd0, state}, {28'd0, S_IDLE});
        checkOutput("t6_abort_tvalid", {31'd0, tvalid}, 32'd0);
        checkOutput("t6_abort_flags", {30'd0, success, error}, 32'd0);
        checkOutput("t6_abort_lanes", {28'd0, activeLanes}, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
